// File: rtl/sync_frame_pkg.sv
// Shared definitions for the sync-framed serial link (transmitter and 1101 detectors).
package sync_frame_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } frame_state_e;

    localparam int SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1101;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Even parity over a payload zero-extended to 32 bits.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, shift-left register presenting its MSB as the serial bit.
module piso_shreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] shreg_r;

    // Payload storage: load wins over shift, zeros enter at the LSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_r <= '0;
        end else if (load) begin
            shreg_r <= din;
        end else if (shift) begin
            shreg_r <= shreg_r << 1'b1;
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign msb = shreg_r[DATA_W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Bit-serial frame transmitter: 1101 sync header, MSB-first payload, optional
// even parity, then a zero gap. Every output is a flop fed from the next-state view.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter bit PAR_EN   = 1'b1,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_out,
    output logic              ser_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_BITS) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

    // A shorter gap could let trailing bits merge with the next header into a false 1101.
    if (GAP_BITS < 2) begin : g_gap_check
        $error("sync_frame_tx: GAP_BITS must be at least 2");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_width_check
        $error("sync_frame_tx: DATA_W must be within 1..32");
    end

    frame_state_e     state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             parity_r;
    logic             ser_out_r, ser_en_r, busy_r, frame_done_r, in_ready_r;
    logic             ser_out_next_s, ser_en_next_s, busy_next_s;
    logic             frame_done_next_s, in_ready_next_s;
    logic             accept_s, shift_s, shreg_msb_s;
    logic [1:0]       sync_idx_s;

    assign accept_s = in_valid & in_ready_r;

    piso_shreg #(.DATA_W(DATA_W)) u_shreg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept_s),
        .shift   (shift_s),
        .din     (in_data),
        .msb     (shreg_msb_s)
    );

    // Next state and bit counter; state_r names the phase of the bit now on ser_out.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                state_next_s = accept_s ? SYNC : IDLE;
                cnt_next_s   = '0;
            end
            SYNC: begin
                if (cnt_r == SYNC_LAST) begin
                    state_next_s = DATA;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == DATA_LAST) begin
                    state_next_s = PAR_EN ? PAR : GAP;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            PAR: begin
                state_next_s = GAP;
                cnt_next_s   = '0;
            end
            GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_next_s = accept_s ? SYNC : IDLE;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state.
    always_comb begin
        sync_idx_s        = 2'd3 - cnt_next_s[1:0];
        shift_s           = (state_next_s == DATA);
        ser_en_next_s     = (state_next_s == SYNC) || (state_next_s == DATA) || (state_next_s == PAR);
        busy_next_s       = (state_next_s != IDLE);
        in_ready_next_s   = (state_next_s == IDLE) ||
                            ((state_next_s == GAP) && (cnt_next_s == GAP_LAST));
        case (state_next_s)
            SYNC:    ser_out_next_s = SYNC_PAT[sync_idx_s];
            DATA:    ser_out_next_s = shreg_msb_s;
            PAR:     ser_out_next_s = parity_r;
            default: ser_out_next_s = 1'b0;
        endcase
        if (PAR_EN) begin
            frame_done_next_s = (state_next_s == PAR);
        end else begin
            frame_done_next_s = (state_next_s == DATA) && (cnt_next_s == DATA_LAST);
        end
    end

    // State, counter, captured parity and the registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            parity_r     <= 1'b0;
            ser_out_r    <= 1'b0;
            ser_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            parity_r     <= accept_s ? even_parity(32'(in_data)) : parity_r;
            ser_out_r    <= ser_out_next_s;
            ser_en_r     <= ser_en_next_s;
            busy_r       <= busy_next_s;
            frame_done_r <= frame_done_next_s;
            in_ready_r   <= in_ready_next_s;
        end
    end

    assign ser_out    = ser_out_r;
    assign ser_en     = ser_en_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign in_ready   = in_ready_r;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: an 8-bit/parity instance and a 4-bit/no-parity instance.
module tb_sync_frame_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid8, in_ready8, ser_out8, ser_en8, busy8, frame_done8;
    logic [7:0] in_data8;
    logic       in_valid4, in_ready4, ser_out4, ser_en4, busy4, frame_done4;
    logic [3:0] in_data4;

    int pass_cnt  = 0;
    int check_cnt = 0;

    sync_frame_tx #(.DATA_W(8), .PAR_EN(1'b1), .GAP_BITS(2)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .ser_out(ser_out8), .ser_en(ser_en8), .busy(busy8),
        .frame_done(frame_done8)
    );

    sync_frame_tx #(.DATA_W(4), .PAR_EN(1'b0), .GAP_BITS(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .ser_out(ser_out4), .ser_en(ser_en4), .busy(busy4),
        .frame_done(frame_done4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples n cycles (at negedge) of one instance, MSB of each vector = first cycle.
    task automatic check_frame(input string tag, input int n, input bit sel4, input bit hold,
                               input bit vary, input logic [7:0] next_data,
                               input logic [63:0] exp_bits, input logic [63:0] exp_ens,
                               input logic [63:0] exp_dones, input logic [63:0] exp_busys,
                               input logic [63:0] exp_readys);
        logic [63:0] bits, ens, dones, busys, readys;
        bits = '0; ens = '0; dones = '0; busys = '0; readys = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel4) begin
                bits   = {bits[62:0], ser_out4};
                ens    = {ens[62:0], ser_en4};
                dones  = {dones[62:0], frame_done4};
                busys  = {busys[62:0], busy4};
                readys = {readys[62:0], in_ready4};
            end else begin
                bits   = {bits[62:0], ser_out8};
                ens    = {ens[62:0], ser_en8};
                dones  = {dones[62:0], frame_done8};
                busys  = {busys[62:0], busy8};
                readys = {readys[62:0], in_ready8};
            end
            if (!hold) begin
                in_valid8 = 1'b0;
                in_valid4 = 1'b0;
            end
            if (vary) in_data8 = 8'($urandom);
            else if (i == 0) in_data8 = next_data;
        end
        check_eq({tag, "_bits"}, bits, exp_bits);
        check_eq({tag, "_en"}, ens, exp_ens);
        check_eq({tag, "_done"}, dones, exp_dones);
        check_eq({tag, "_busy"}, busys, exp_busys);
        check_eq({tag, "_ready"}, readys, exp_readys);
    endtask

    // True when header+payload+parity contains 1101 only at the header.
    function automatic bit payload_ok(input logic [7:0] p);
        logic [12:0] f;
        int n;
        f = {4'b1101, p, ^p};
        n = 0;
        for (int i = 0; i <= 9; i++) begin
            if (f[12-i -: 4] == 4'b1101) n++;
        end
        return n == 1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] pay [100];
        logic [2:0] hist;
        bit         hit, pos_ok, prev_en, pending;
        int         hits, en_idx, k, frames;

        reset_n = 1'b0;
        in_valid8 = 1'b0; in_data8 = 8'h00;
        in_valid4 = 1'b0; in_data4 = 4'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_out8", {ser_out8, ser_en8, busy8, frame_done8, in_ready8}, 5'b00000);
        check_eq("rst_out4", {ser_out4, ser_en4, busy4, frame_done4, in_ready4}, 5'b00000);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", in_ready8, 1'b1);

        // Single frame A5 with parity
        in_valid8 = 1'b1; in_data8 = 8'hA5;
        check_frame("a5", 15, 1'b0, 1'b0, 1'b0, 8'hA5,
                    15'b110110100101000, 15'b111111111111100, 15'b000000000000100,
                    15'h7FFF, 15'b000000000000001);
        @(negedge clk);
        check_eq("a5_idle", {busy8, in_ready8}, 2'b01);

        // Back-to-back 01 then FF with in_valid held
        in_valid8 = 1'b1; in_data8 = 8'h01;
        check_frame("b2b_1", 15, 1'b0, 1'b1, 1'b0, 8'hFF,
                    15'b110100000001100, 15'b111111111111100, 15'b000000000000100,
                    15'h7FFF, 15'b000000000000001);
        check_frame("b2b_2", 15, 1'b0, 1'b0, 1'b0, 8'hFF,
                    15'b110111111111000, 15'b111111111111100, 15'b000000000000100,
                    15'h7FFF, 15'b000000000000001);
        @(negedge clk);
        check_eq("b2b_idle", busy8, 1'b0);

        // Held in_valid with changing in_data during frame 3C
        in_valid8 = 1'b1; in_data8 = 8'h3C;
        check_frame("hold3c", 15, 1'b0, 1'b1, 1'b1, 8'h00,
                    15'b110100111100000, 15'b111111111111100, 15'b000000000000100,
                    15'h7FFF, 15'b000000000000001);
        @(negedge clk);
        check_eq("hold3c_reaccept", {ser_en8, ser_out8, busy8, in_ready8}, 4'b1110);
        in_valid8 = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("hold3c_idle", {busy8, ser_en8, in_ready8}, 3'b001);

        // Asynchronous reset in the third DATA cycle of frame E7
        in_valid8 = 1'b1; in_data8 = 8'hE7;
        repeat (7) begin
            @(negedge clk);
            in_valid8 = 1'b0;
        end
        check_eq("mid_pre", {ser_out8, ser_en8, busy8}, 3'b111);
        #2 reset_n = 1'b0;
        #1 check_eq("mid_async", {ser_out8, ser_en8, busy8, frame_done8, in_ready8}, 5'b00000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 check_eq("mid_rel0", in_ready8, 1'b0);
        @(negedge clk);
        check_eq("mid_rel1", {in_ready8, ser_en8, ser_out8}, 3'b100);
        in_valid8 = 1'b1; in_data8 = 8'h55;
        check_frame("after55", 15, 1'b0, 1'b0, 1'b0, 8'h55,
                    15'b110101010101000, 15'b111111111111100, 15'b000000000000100,
                    15'h7FFF, 15'b000000000000001);

        // DATA_W=4, no parity, payload B
        in_valid4 = 1'b1; in_data4 = 4'hB;
        check_frame("w4", 10, 1'b1, 1'b0, 1'b0, 8'h00,
                    10'b1101101100, 10'b1111111100, 10'b0000000100,
                    10'h3FF, 10'b0000000001);
        @(negedge clk);

        // Loopback into a 1101 overlapping detector model, 100 back-to-back frames
        for (int i = 0; i < 100; i++) begin
            logic [7:0] p;
            p = 8'h00;
            for (int t = 0; t < 1000; t++) begin
                p = 8'($urandom);
                if (payload_ok(p)) break;
                p = 8'h00;
            end
            pay[i] = p;
        end
        hist = 3'b000; hits = 0; en_idx = 0; pos_ok = 1'b0; prev_en = 1'b0;
        pending = 1'b0; k = 0; frames = 0;
        in_data8 = pay[0]; in_valid8 = 1'b1;
        for (int cyc = 0; cyc < 1700 && frames < 100; cyc++) begin
            @(negedge clk);
            if (pending) begin
                k++;
                if (k < 100) in_data8 = pay[k];
                else in_valid8 = 1'b0;
                pending = 1'b0;
            end
            hit  = ({hist, ser_out8} == 4'b1101);
            hist = {hist[1:0], ser_out8};
            if (ser_en8) begin
                if (!prev_en) begin
                    en_idx = 0; hits = 0; pos_ok = 1'b0;
                end else begin
                    en_idx++;
                end
            end
            if (hit) begin
                hits++;
                if (ser_en8 && en_idx == 3) pos_ok = 1'b1;
            end
            if (frame_done8) begin
                check_eq("loop_hits", hits, 1);
                check_eq("loop_pos", pos_ok, 1'b1);
                frames++;
            end
            prev_en = ser_en8;
            if (in_valid8 && in_ready8) pending = 1'b1;
        end
        check_eq("loop_frames", frames, 100);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
